// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the frame-buffer display path.
// The capture writer uses the same ADDR_W, PIX_W and FB_DEPTH.
package vga_fb_pkg;

    // 640x480@60 default timing, in pixels / lines
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned FB_DEPTH = DEF_H_ACTIVE * DEF_V_ACTIVE;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned PIX_W    = 12;

    // h/v counter width; covers totals up to 1024
    localparam int unsigned CNT_W = 10;

    // Per-pixel control bits carried alongside the RAM read
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic first;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

    // RGB444 pixel as stored in the frame buffer
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA h/v counters with active/sync decode.
// Control outputs are combinational from the counters (stage 0).
module vga_timing_gen
    import vga_fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic     i_clk,
    input  logic     i_rst,
    output vga_ctl_t o_ctl,
    output logic     o_frame_end
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Pixel counter wraps each line; line counter advances on the pixel wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Stage-0 decode of visibility, syncs and the (0,0) marker
    always_comb begin
        o_ctl.active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        o_ctl.hs_n   = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
        o_ctl.vs_n   = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
        o_ctl.first  = (r_h_cnt == '0) && (r_v_cnt == '0);
        o_frame_end  = w_h_last && w_v_last;
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Display-side frame-buffer reader: issues one RAM read per visible
// pixel and drives the returned RGB444 onto the VGA pins, with syncs
// delayed so colour and sync leave on the same cycle (2+RD_LAT latency).
module vga_fb_reader
    import vga_fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              PCLK_VGA,
    input  logic              rst,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              frame_start
);

    vga_ctl_t          w_ctl;
    logic              w_frame_end;
    rgb444_t           w_pix;
    logic [ADDR_W-1:0] r_addr_cnt;
    vga_ctl_t          r_dl [RD_LAT+1];

    assign w_pix = rd_data;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (PCLK_VGA),
        .i_rst       (rst),
        .o_ctl       (w_ctl),
        .o_frame_end (w_frame_end)
    );

    // Linear address tracks visible pixels; cleared once per frame
    always_ff @(posedge PCLK_VGA or posedge rst) begin
        if (rst) begin
            r_addr_cnt <= '0;
        end else if (w_frame_end) begin
            r_addr_cnt <= '0;
        end else if (w_ctl.active) begin
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        end
    end

    // Stage 1: read request; address holds through blanking
    always_ff @(posedge PCLK_VGA or posedge rst) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= w_ctl.active;
            if (w_ctl.active) begin
                rd_addr <= r_addr_cnt;
            end
        end
    end

    // Control delay line: 1 stage for the request register plus RD_LAT for the RAM
    always_ff @(posedge PCLK_VGA or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                r_dl[i] <= CTL_IDLE;
            end
        end else begin
            r_dl[0] <= w_ctl;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    // Output stage: RAM pixel when visible, forced black in blanking
    always_ff @(posedge PCLK_VGA or posedge rst) begin
        if (rst) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (r_dl[RD_LAT].active) begin
                VGA_R <= w_pix.r;
                VGA_G <= w_pix.g;
                VGA_B <= w_pix.b;
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
            VGA_HS      <= r_dl[RD_LAT].hs_n;
            VGA_VS      <= r_dl[RD_LAT].vs_n;
            frame_start <= r_dl[RD_LAT].first;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: full-size timing with RD_LAT=1 and 2, plus a
// shrunken geometry (RD_LAT=1) so whole frames fit in a short run.
module tb_vga_fb_reader;
    import vga_fb_pkg::*;

    localparam int SH_ACT = 16, SH_FP = 2, SH_SY = 4, SH_BP = 3;
    localparam int SV_ACT = 6,  SV_FP = 1, SV_SY = 2, SV_BP = 2;
    localparam int MAIN_CYC = 5200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] d_addr [3];
    logic              d_en   [3];
    logic [PIX_W-1:0]  d_data [3];
    logic [3:0]        d_r [3], d_g [3], d_b [3];
    logic              d_hs [3], d_vs [3], d_fs [3];
    logic [11:0]       seed;

    vga_fb_reader #(.RD_LAT(1)) u_dut_l1 (
        .PCLK_VGA(clk), .rst(rst), .rd_addr(d_addr[0]), .rd_en(d_en[0]), .rd_data(d_data[0]),
        .VGA_R(d_r[0]), .VGA_G(d_g[0]), .VGA_B(d_b[0]), .VGA_HS(d_hs[0]), .VGA_VS(d_vs[0]),
        .frame_start(d_fs[0]));

    vga_fb_reader #(.RD_LAT(2)) u_dut_l2 (
        .PCLK_VGA(clk), .rst(rst), .rd_addr(d_addr[1]), .rd_en(d_en[1]), .rd_data(d_data[1]),
        .VGA_R(d_r[1]), .VGA_G(d_g[1]), .VGA_B(d_b[1]), .VGA_HS(d_hs[1]), .VGA_VS(d_vs[1]),
        .frame_start(d_fs[1]));

    vga_fb_reader #(
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SY), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SY), .V_BP(SV_BP), .RD_LAT(1)
    ) u_dut_sm (
        .PCLK_VGA(clk), .rst(rst), .rd_addr(d_addr[2]), .rd_en(d_en[2]), .rd_data(d_data[2]),
        .VGA_R(d_r[2]), .VGA_G(d_g[2]), .VGA_B(d_b[2]), .VGA_HS(d_hs[2]), .VGA_VS(d_vs[2]),
        .frame_start(d_fs[2]));

    // RAM models: return addr[11:0] ^ seed after RD_LAT cycles
    logic [11:0] ram0, ram1a, ram1b, ram2;
    always @(posedge clk) begin
        ram0  <= d_addr[0][11:0] ^ seed;
        ram1a <= d_addr[1][11:0] ^ seed;
        ram1b <= ram1a;
        ram2  <= d_addr[2][11:0] ^ seed;
    end
    assign d_data[0] = ram0;
    assign d_data[1] = ram1b;
    assign d_data[2] = ram2;

    typedef struct { int hact, hfp, hsync, hbp, vact, vfp, vsync, vbp, lat; } geo_t;
    typedef struct { bit active, hs_n, vs_n, first; int addr; } s0_t;
    typedef struct packed { logic [11:0] rgb; logic hs; logic vs; logic fs; } out_t;
    typedef enum { K_STG1, K_RGB, K_HS, K_VS, K_FS } kind_e;
    typedef struct { int d; int c; kind_e k; logic [63:0] val; } vec_t;
    typedef enum { PH_PRE, PH_MAIN, PH_POST } ph_e;

    geo_t  geo [3];
    out_t  sq0 [$];
    out_t  sq1 [$];
    out_t  sq2 [$];
    vec_t  tbl [$];
    ph_e   phase;
    int    c;
    int    last_addr [3];
    int    n_checks = 0;
    int    n_fail = 0;
    int    hs_first [3], hs_fall [3], hs_per [3], hs_wid [3];
    int    vs_fall [3], vs_per [3], vs_wid [3], fs_cnt [3];
    bit    hs_prev [3], vs_prev [3];

    function automatic int htot(int d);
        return geo[d].hact + geo[d].hfp + geo[d].hsync + geo[d].hbp;
    endfunction

    function automatic int vtot(int d);
        return geo[d].vact + geo[d].vfp + geo[d].vsync + geo[d].vbp;
    endfunction

    function automatic s0_t model_s0(int d, int idx);
        s0_t s;
        int h, v;
        h = idx % htot(d);
        v = (idx / htot(d)) % vtot(d);
        s.active = (h < geo[d].hact) && (v < geo[d].vact);
        s.hs_n   = !((h >= geo[d].hact + geo[d].hfp) && (h < geo[d].hact + geo[d].hfp + geo[d].hsync));
        s.vs_n   = !((v >= geo[d].vact + geo[d].vfp) && (v < geo[d].vact + geo[d].vfp + geo[d].vsync));
        s.first  = (h == 0) && (v == 0);
        s.addr   = v * geo[d].hact + h;
        return s;
    endfunction

    function automatic logic [63:0] stg(bit en, int addr);
        return 64'({en, 19'(addr)});
    endfunction

    task automatic chk_eq(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, c, act, exp);
        end
    endtask

    task automatic add(input int d, input int cc, input kind_e k, input logic [63:0] v);
        vec_t e;
        e.d = d; e.c = cc; e.k = k; e.val = v;
        tbl.push_back(e);
    endtask

    task automatic sb_push(input int d, input out_t e);
        case (d)
            0: sq0.push_back(e);
            1: sq1.push_back(e);
            default: sq2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d, output out_t e, output bit ok);
        ok = 1'b1;
        e = '0;
        case (d)
            0: if (sq0.size() > 0) e = sq0.pop_front(); else ok = 1'b0;
            1: if (sq1.size() > 0) e = sq1.pop_front(); else ok = 1'b0;
            default: if (sq2.size() > 0) e = sq2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Called at release: outputs are idle for 1+RD_LAT cycles before pixel (0,0)
    task automatic reset_model();
        out_t idle;
        idle = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        c = 0;
        sq0.delete(); sq1.delete(); sq2.delete();
        for (int d = 0; d < 3; d++) begin
            last_addr[d] = 0;
            for (int k = 0; k <= geo[d].lat; k++) sb_push(d, idle);
        end
    endtask

    task automatic check_reset();
        for (int d = 0; d < 3; d++) begin
            chk_eq("reset_state", d,
                   64'({d_en[d], d_addr[d], d_r[d], d_g[d], d_b[d], d_hs[d], d_vs[d], d_fs[d]}),
                   64'({1'b0, 19'd0, 12'h000, 1'b1, 1'b1, 1'b0}));
        end
    endtask

    task automatic check_cycle();
        s0_t s;
        out_t e, got, exp_o;
        bit ok;
        logic [63:0] a;
        int dd;
        for (int d = 0; d < 3; d++) begin
            s = model_s0(d, c - 1);
            if (s.active) last_addr[d] = s.addr;
            chk_eq("stage1", d, 64'({d_en[d], d_addr[d]}), stg(s.active, last_addr[d]));
            chk_eq("addr_bound", d,
                   64'(d_en[d] && (int'(d_addr[d]) > geo[d].hact * geo[d].vact - 1)), 64'd0);
            e.rgb = s.active ? (12'(s.addr) ^ seed) : 12'h000;
            e.hs  = s.hs_n;
            e.vs  = s.vs_n;
            e.fs  = s.first;
            sb_push(d, e);
            sb_pop(d, exp_o, ok);
            got = '{rgb: {d_r[d], d_g[d], d_b[d]}, hs: d_hs[d], vs: d_vs[d], fs: d_fs[d]};
            if (!ok) chk_eq("sb_underflow", d, 64'd1, 64'd0);
            else chk_eq("pixel_out", d, 64'(got), 64'(exp_o));

            if (phase == PH_MAIN) begin
                if (hs_prev[d] && !d_hs[d]) begin
                    if (hs_fall[d] >= 0) hs_per[d] = c - hs_fall[d];
                    else hs_first[d] = c;
                    hs_fall[d] = c;
                end
                if (!hs_prev[d] && d_hs[d] && hs_fall[d] >= 0) hs_wid[d] = c - hs_fall[d];
                if (vs_prev[d] && !d_vs[d]) begin
                    if (vs_fall[d] >= 0) vs_per[d] = c - vs_fall[d];
                    vs_fall[d] = c;
                end
                if (!vs_prev[d] && d_vs[d] && vs_fall[d] >= 0) vs_wid[d] = c - vs_fall[d];
                hs_prev[d] = d_hs[d];
                vs_prev[d] = d_vs[d];
                if (d_fs[d]) fs_cnt[d]++;
            end
        end

        if (phase == PH_MAIN) begin
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].c == c) begin
                    dd = tbl[i].d;
                    case (tbl[i].k)
                        K_STG1:  a = 64'({d_en[dd], d_addr[dd]});
                        K_RGB:   a = 64'({d_r[dd], d_g[dd], d_b[dd]});
                        K_HS:    a = 64'(d_hs[dd]);
                        K_VS:    a = 64'(d_vs[dd]);
                        default: a = 64'(d_fs[dd]);
                    endcase
                    chk_eq($sformatf("vec%0d", i), dd, a, tbl[i].val);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c++;
            check_cycle();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst  = 1'b1;
        seed = 12'h000;
        c    = 0;
        phase = PH_PRE;
        geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
        geo[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
        geo[2] = '{SH_ACT, SH_FP, SH_SY, SH_BP, SV_ACT, SV_FP, SV_SY, SV_BP, 1};

        // Directed vectors, cycle counted from reset release (first edge = 1)
        add(0, 1,    K_STG1, stg(1, 0));
        add(0, 640,  K_STG1, stg(1, 639));
        add(0, 641,  K_STG1, stg(0, 639));
        add(0, 800,  K_STG1, stg(0, 639));
        add(0, 801,  K_STG1, stg(1, 640));
        add(0, 802,  K_STG1, stg(1, 641));
        add(0, 3,    K_RGB,  64'h000);
        add(0, 4,    K_RGB,  64'h001);
        add(0, 642,  K_RGB,  64'h27F);
        add(0, 643,  K_RGB,  64'h000);
        add(0, 803,  K_RGB,  64'h280);
        add(0, 5058, K_RGB,  64'hFFF);
        add(0, 5059, K_RGB,  64'h000);
        add(0, 658,  K_HS,   64'd1);
        add(0, 659,  K_HS,   64'd0);
        add(0, 754,  K_HS,   64'd0);
        add(0, 755,  K_HS,   64'd1);
        add(0, 2,    K_FS,   64'd0);
        add(0, 3,    K_FS,   64'd1);
        add(0, 4,    K_FS,   64'd0);
        add(1, 5,    K_RGB,  64'h001);
        add(1, 5059, K_RGB,  64'hFFF);
        add(1, 5060, K_RGB,  64'h000);
        add(1, 659,  K_HS,   64'd1);
        add(1, 660,  K_HS,   64'd0);
        add(1, 755,  K_HS,   64'd0);
        add(1, 756,  K_HS,   64'd1);
        add(1, 3,    K_FS,   64'd0);
        add(1, 4,    K_FS,   64'd1);
        add(2, 17,   K_STG1, stg(0, 15));
        add(2, 26,   K_STG1, stg(1, 16));
        add(2, 141,  K_STG1, stg(1, 95));
        add(2, 142,  K_STG1, stg(0, 95));
        add(2, 151,  K_STG1, stg(0, 95));
        add(2, 275,  K_STG1, stg(0, 95));
        add(2, 276,  K_STG1, stg(1, 0));
        add(2, 143,  K_RGB,  64'h05F);
        add(2, 144,  K_RGB,  64'h000);
        add(2, 177,  K_VS,   64'd1);
        add(2, 178,  K_VS,   64'd0);
        add(2, 227,  K_VS,   64'd0);
        add(2, 228,  K_VS,   64'd1);
        add(2, 3,    K_FS,   64'd1);
        add(2, 278,  K_FS,   64'd1);
        add(2, 279,  K_FS,   64'd0);

        // Power-on reset
        repeat (3) begin
            @(negedge clk);
            check_reset();
        end
        rst = 1'b0;
        reset_model();
        run(1000 + int'($urandom_range(0, 400)));

        // 5-cycle reset asserted mid-frame
        rst = 1'b1;
        #1 check_reset();
        repeat (5) begin
            @(negedge clk);
            check_reset();
        end
        rst = 1'b0;
        reset_model();
        phase = PH_MAIN;
        for (int d = 0; d < 3; d++) begin
            hs_first[d] = -1; hs_fall[d] = -1; hs_per[d] = -1; hs_wid[d] = -1;
            vs_fall[d] = -1; vs_per[d] = -1; vs_wid[d] = -1; fs_cnt[d] = 0;
            hs_prev[d] = 1'b1; vs_prev[d] = 1'b1;
        end
        run(MAIN_CYC);

        for (int d = 0; d < 3; d++) begin
            chk_eq("hs_first_fall", d, 64'(hs_first[d]), 64'(geo[d].hact + geo[d].hfp + 2 + geo[d].lat));
            chk_eq("hs_width", d, 64'(hs_wid[d]), 64'(geo[d].hsync));
            chk_eq("hs_period", d, 64'(hs_per[d]), 64'(htot(d)));
            chk_eq("frame_start_count", d, 64'(fs_cnt[d]),
                   64'((MAIN_CYC - (2 + geo[d].lat)) / (htot(d) * vtot(d)) + 1));
        end
        chk_eq("vs_width", 2, 64'(vs_wid[2]), 64'(geo[2].vsync * htot(2)));
        chk_eq("vs_period", 2, 64'(vs_per[2]), 64'(htot(2) * vtot(2)));

        // Mid-frame reset on the small geometry at line 3, h=10, new data pattern
        phase = PH_POST;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            run(1);
            if (((c - 1) % (htot(2) * vtot(2))) == 3 * htot(2) + 10) hit = 1'b1;
        end
        chk_eq("midframe_reach", 2, 64'(hit), 64'd1);
        rst  = 1'b1;
        seed = 12'($urandom_range(1, 4095));
        #1 check_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset();
        end
        rst = 1'b0;
        reset_model();
        run(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
